// File: rtl/risc_processor_wrapper.sv
// risc_processor_wrapper: 8-bit, 16-register three-phase RISC core with a fixed program ROM
// and four registered output ports. One 16-bit instruction completes every three clocks.

module timing_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       halt,
  output logic [2:0] phase
);
  localparam logic [2:0] T1 = 3'b001;
  localparam logic [2:0] T2 = 3'b010;
  localparam logic [2:0] T3 = 3'b100;

  logic [2:0] state;
  logic [2:0] state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= T1;
    else       state <= state_next;
  end

  // Halt is only ever set on the edge leaving T3, so a halted ring sits in T1.
  always_comb begin
    state_next = state;
    if (!halt) begin
      case (state)
        T1:      state_next = T2;
        T2:      state_next = T3;
        T3:      state_next = T1;
        default: state_next = T1;
      endcase
    end
  end

  // phase is the one-hot ring itself: {T3,T2,T1}.
  always_comb begin
    phase = state;
  end
endmodule

module reg_file (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr_a,
  input  logic [3:0] raddr_b,
  input  logic [3:0] raddr_c,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic [7:0] rdata_c
);
  logic [7:0] reg_file_out [16];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) reg_file_out[i] <= 8'h00;
    end else if (we) begin
      reg_file_out[waddr] <= wdata;
    end
  end

  // Reads are asynchronous, so an in-flight instruction sees the pre-write value.
  assign rdata_a = reg_file_out[raddr_a];
  assign rdata_b = reg_file_out[raddr_b];
  assign rdata_c = reg_file_out[raddr_c];
endmodule

module risc_core (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] inp1,
  input  logic [7:0] inp2,
  input  logic [7:0] inp3,
  input  logic [7:0] inp4,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [7:0] out4,
  output logic [7:0] dataout1,
  output logic [7:0] dataout2,
  output logic [7:0] alu_out,
  output logic       out_port_write
);
  localparam logic [2:0] T1 = 3'b001;
  localparam logic [2:0] T3 = 3'b100;

  localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5, OP_NOT = 4'h6, OP_SHL = 4'h7, OP_SHR = 4'h8;
  localparam logic [3:0] OP_MOV = 4'h9, OP_IN  = 4'hA, OP_OUT = 4'hB, OP_LDI = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD, OP_JZ  = 4'hE, OP_HLT = 4'hF;

  logic [7:0]  pc;
  logic [15:0] ir;
  logic        halt;
  logic [2:0]  phase;
  logic [15:0] rom_word;
  logic [7:0]  pc_next;
  logic [7:0]  inp_sel;
  logic [7:0]  jz_value;
  logic        reg_write;
  logic [7:0]  out_reg [4];

  logic [3:0] opcode, destin, source1, source2;
  logic [7:0] imm;
  assign opcode  = ir[15:12];
  assign destin  = ir[11:8];
  assign source1 = ir[7:4];
  assign source2 = ir[3:0];
  assign imm     = ir[7:0];

  timing_gen timing_gen (
    .clk   (clk),
    .reset (reset),
    .halt  (halt),
    .phase (phase)
  );

  reg_file reg_file (
    .clk     (clk),
    .reset   (reset),
    .we      (reg_write),
    .waddr   (destin),
    .wdata   (alu_out),
    .raddr_a (source1),
    .raddr_b (source2),
    .raddr_c (destin),
    .rdata_a (dataout1),
    .rdata_b (dataout2),
    .rdata_c (jz_value)
  );

  always_comb begin
    case (pc)
      8'd0:    rom_word = 16'hA100;  // IN  R1, port1
      8'd1:    rom_word = 16'hA210;  // IN  R2, port2
      8'd2:    rom_word = 16'hA320;  // IN  R3, port3
      8'd3:    rom_word = 16'h1612;  // ADD R6, R1, R2
      8'd4:    rom_word = 16'h2A23;  // SUB R10, R2, R3
      8'd5:    rom_word = 16'h3D21;  // AND R13, R2, R1
      8'd6:    rom_word = 16'h4E13;  // OR  R14, R1, R3
      8'd7:    rom_word = 16'h5F23;  // XOR R15, R2, R3
      8'd8:    rom_word = 16'hB060;  // OUT port1, R6
      8'd9:    rom_word = 16'hB1F0;  // OUT port2, R15
      default: rom_word = 16'hF000;  // HLT
    endcase
  end

  always_comb begin
    case (source1[1:0])
      2'd0:    inp_sel = inp1;
      2'd1:    inp_sel = inp2;
      2'd2:    inp_sel = inp3;
      default: inp_sel = inp4;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_ADD:  alu_out = dataout1 + dataout2;
      OP_SUB:  alu_out = dataout1 - dataout2;
      OP_AND:  alu_out = dataout1 & dataout2;
      OP_OR:   alu_out = dataout1 | dataout2;
      OP_XOR:  alu_out = dataout1 ^ dataout2;
      OP_NOT:  alu_out = ~dataout1;
      OP_SHL:  alu_out = {dataout1[6:0], 1'b0};
      OP_SHR:  alu_out = {1'b0, dataout1[7:1]};
      OP_MOV:  alu_out = dataout1;
      OP_IN:   alu_out = inp_sel;
      OP_LDI:  alu_out = imm;
      default: alu_out = 8'h00;
    endcase
  end

  always_comb begin
    reg_write      = 1'b0;
    out_port_write = 1'b0;
    if (phase == T3 && !halt) begin
      reg_write      = (opcode >= OP_ADD && opcode <= OP_IN) || opcode == OP_LDI;
      out_port_write = (opcode == OP_OUT);
    end
  end

  // HLT leaves the PC pointing at itself.
  always_comb begin
    case (opcode)
      OP_JMP:  pc_next = imm;
      OP_JZ:   pc_next = (jz_value == 8'h00) ? imm : pc + 8'd1;
      OP_HLT:  pc_next = pc;
      default: pc_next = pc + 8'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= 8'h00;
      ir   <= 16'h0000;
      halt <= 1'b0;
      for (int i = 0; i < 4; i++) out_reg[i] <= 8'h00;
    end else if (!halt) begin
      case (phase)
        T1: ir <= rom_word;
        T3: begin
          pc <= pc_next;
          if (opcode == OP_HLT) halt <= 1'b1;
          if (out_port_write) out_reg[destin[1:0]] <= dataout1;
        end
        default: ;
      endcase
    end
  end

  assign out1 = out_reg[0];
  assign out2 = out_reg[1];
  assign out3 = out_reg[2];
  assign out4 = out_reg[3];
endmodule

module risc_processor_wrapper (
  input  logic       clk,
  input  logic       Reset,
  input  logic [7:0] InpExtWorld1,
  input  logic [7:0] InpExtWorld2,
  input  logic [7:0] InpExtWorld3,
  input  logic [7:0] InpExtWorld4,
  output logic [7:0] OutExtWorld1,
  output logic [7:0] OutExtWorld2,
  output logic [7:0] OutExtWorld3,
  output logic [7:0] OutExtWorld4,
  output logic [7:0] Dataout1,
  output logic [7:0] Dataout2,
  output logic [7:0] ALUout,
  output logic       OUTportWrite
);
  risc_core uut (
    .clk            (clk),
    .reset          (Reset),
    .inp1           (InpExtWorld1),
    .inp2           (InpExtWorld2),
    .inp3           (InpExtWorld3),
    .inp4           (InpExtWorld4),
    .out1           (OutExtWorld1),
    .out2           (OutExtWorld2),
    .out3           (OutExtWorld3),
    .out4           (OutExtWorld4),
    .dataout1       (Dataout1),
    .dataout2       (Dataout2),
    .alu_out        (ALUout),
    .out_port_write (OUTportWrite)
  );
endmodule

// File: tb/tb_risc_processor_wrapper.sv
// Bench for risc_processor_wrapper: instruction-level reference model of the fixed program,
// randomized input ports and randomized reset-abort points.

module tb_risc_processor_wrapper;
  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] inp [4];
  logic [7:0] OutExtWorld1, OutExtWorld2, OutExtWorld3, OutExtWorld4;
  logic [7:0] Dataout1, Dataout2, ALUout;
  logic       OUTportWrite;

  always #5 clk = ~clk;

  risc_processor_wrapper dut (
    .clk          (clk),
    .Reset        (Reset),
    .InpExtWorld1 (inp[0]),
    .InpExtWorld2 (inp[1]),
    .InpExtWorld3 (inp[2]),
    .InpExtWorld4 (inp[3]),
    .OutExtWorld1 (OutExtWorld1),
    .OutExtWorld2 (OutExtWorld2),
    .OutExtWorld3 (OutExtWorld3),
    .OutExtWorld4 (OutExtWorld4),
    .Dataout1     (Dataout1),
    .Dataout2     (Dataout2),
    .ALUout       (ALUout),
    .OUTportWrite (OUTportWrite)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q [$];
  logic [15:0] prog [11];
  logic [7:0]  m_regs [16];
  logic [7:0]  m_out [4];
  logic [7:0]  m_pc;
  logic        m_halt;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] dut_out(input int i);
    case (i)
      0:       return OutExtWorld1;
      1:       return OutExtWorld2;
      2:       return OutExtWorld3;
      default: return OutExtWorld4;
    endcase
  endfunction

  // Each OUT pulse must carry the register value the model queued for it.
  always @(negedge clk) begin
    if (OUTportWrite === 1'b1) begin
      if (exp_q.size() == 0) check("out_unexpected", 1'b1, 1'b0);
      else                   check("out_data", Dataout1, exp_q.pop_front());
    end
  end

  task automatic do_reset();
    Reset = 1'b1;
    step();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    for (int i = 0; i < 4; i++)  m_out[i] = 8'h00;
    m_pc = 8'h00;
    m_halt = 1'b0;
    exp_q.delete();
    check("rst_pc", dut.uut.pc, 8'h00);
    check("rst_phase", dut.uut.phase, 3'b001);
    check("rst_owr", OUTportWrite, 1'b0);
    for (int i = 0; i < 16; i++) check("rst_reg", dut.uut.reg_file.reg_file_out[i], 8'h00);
    for (int i = 0; i < 4; i++)  check("rst_out", dut_out(i), 8'h00);
    Reset = 1'b0;
  endtask

  // Runs one instruction from a T1 sample point to the next T1 sample point.
  task automatic run_instr();
    logic [15:0] ins;
    logic [3:0]  op, d, s1, s2;
    logic [7:0]  a, b, res;
    logic        wr;
    ins = (m_pc <= 8'd10) ? prog[m_pc[3:0]] : 16'hF000;
    op = ins[15:12]; d = ins[11:8]; s1 = ins[7:4]; s2 = ins[3:0];
    a = m_regs[s1];
    b = m_regs[s2];
    check("pc", dut.uut.pc, m_pc);
    check("phase_t1", dut.uut.phase, 3'b001);
    if (op == 4'hB) exp_q.push_back(a);
    step();
    check("owr_t2", OUTportWrite, 1'b0);
    step();
    wr = 1'b1;
    case (op)
      4'h1:    res = a + b;
      4'h2:    res = a - b;
      4'h3:    res = a & b;
      4'h4:    res = a | b;
      4'h5:    res = a ^ b;
      4'h6:    res = ~a;
      4'h7:    res = a << 1;
      4'h8:    res = a >> 1;
      4'h9:    res = a;
      4'hA:    res = inp[s1[1:0]];
      4'hC:    res = ins[7:0];
      default: begin res = 8'h00; wr = 1'b0; end
    endcase
    check("dout1", Dataout1, a);
    check("dout2", Dataout2, b);
    check("alu", ALUout, res);
    check("regwr", dut.uut.reg_write, wr);
    check("owr_t3", OUTportWrite, op == 4'hB);
    if (wr) m_regs[d] = res;
    case (op)
      4'hB:    begin m_out[d[1:0]] = a; m_pc = m_pc + 8'd1; end
      4'hD:    m_pc = ins[7:0];
      4'hE:    m_pc = (m_regs[d] == 8'h00) ? ins[7:0] : m_pc + 8'd1;
      4'hF:    m_halt = 1'b1;
      default: m_pc = m_pc + 8'd1;
    endcase
    step();
  endtask

  task automatic run_program();
    for (int n = 0; n < 20 && !m_halt; n++) run_instr();
    check("halt_reached", m_halt, 1'b1);
    check("halt_pc", dut.uut.pc, m_pc);
    for (int i = 0; i < 16; i++) check("end_reg", dut.uut.reg_file.reg_file_out[i], m_regs[i]);
    for (int i = 0; i < 4; i++)  check("end_out", dut_out(i), m_out[i]);
    check("out_missed", exp_q.size(), 16'd0);
  endtask

  task automatic check_fixed_results();
    check("r1_fixed",  dut.uut.reg_file.reg_file_out[1],  8'h04);
    check("r2_fixed",  dut.uut.reg_file.reg_file_out[2],  8'h0C);
    check("r3_fixed",  dut.uut.reg_file.reg_file_out[3],  8'h03);
    check("r6_fixed",  dut.uut.reg_file.reg_file_out[6],  8'h10);
    check("r10_fixed", dut.uut.reg_file.reg_file_out[10], 8'h09);
    check("r13_fixed", dut.uut.reg_file.reg_file_out[13], 8'h04);
    check("r14_fixed", dut.uut.reg_file.reg_file_out[14], 8'h07);
    check("r15_fixed", dut.uut.reg_file.reg_file_out[15], 8'h0F);
    check("out1_fixed", OutExtWorld1, 8'h10);
    check("out2_fixed", OutExtWorld2, 8'h0F);
    check("out3_fixed", OutExtWorld3, 8'h00);
    check("out4_fixed", OutExtWorld4, 8'h00);
  endtask

  task automatic set_fixed_inputs();
    inp[0] = 8'h04; inp[1] = 8'h0C; inp[2] = 8'h03; inp[3] = 8'h3C;
  endtask

  initial begin
    logic [7:0] hold_regs [16];
    int k, ph;
    prog[0] = 16'hA100; prog[1] = 16'hA210; prog[2]  = 16'hA320; prog[3] = 16'h1612;
    prog[4] = 16'h2A23; prog[5] = 16'h3D21; prog[6]  = 16'h4E13; prog[7] = 16'h5F23;
    prog[8] = 16'hB060; prog[9] = 16'hB1F0; prog[10] = 16'hF000;
    Reset = 1'b1;
    set_fixed_inputs();

    do_reset();
    run_program();
    check_fixed_results();

    for (int i = 0; i < 16; i++) hold_regs[i] = dut.uut.reg_file.reg_file_out[i];
    for (int c = 0; c < 120; c++) begin
      step();
      check("halt_hold_pc", dut.uut.pc, 8'h0A);
      check("halt_phase", dut.uut.phase, 3'b001);
      check("halt_owr", OUTportWrite, 1'b0);
    end
    for (int i = 0; i < 16; i++) check("halt_reg", dut.uut.reg_file.reg_file_out[i], hold_regs[i]);

    // Restart from halt, then abort the ADD at PC=03 during T2.
    do_reset();
    for (int n = 0; n < 3; n++) run_instr();
    step();
    check("abort_pc_pre", dut.uut.pc, 8'h03);
    do_reset();
    check("abort_r6", dut.uut.reg_file.reg_file_out[6], 8'h00);
    run_program();
    check_fixed_results();

    for (int iter = 0; iter < 8; iter++) begin
      for (int i = 0; i < 4; i++) inp[i] = 8'($urandom_range(0, 255));
      do_reset();
      k  = $urandom_range(0, 10);
      ph = $urandom_range(0, 2);
      for (int n = 0; n < k; n++) run_instr();
      for (int n = 0; n < ph; n++) step();
      do_reset();
      for (int i = 0; i < 4; i++) inp[i] = 8'($urandom_range(0, 255));
      run_program();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/risc_processor_wrapper.md
# risc_processor_wrapper

Top-level wrapper around an 8-bit, 16-register, three-phase (T1/T2/T3) RISC core with an internal program ROM and four 8-bit input and four 8-bit output ports. The core fetches, decodes and executes one 16-bit instruction every three clocks. Register-file read data and the ALU result are exported for debug. The block is the complete processor as seen by the board or testbench.

## Interface
- No parameters. The program ROM contents are fixed and listed under Operation.
- clk: input, 1 bit. Single clock; all state changes on the rising edge.
- Reset: input, 1 bit. Synchronous, active-high.
- InpExtWorld1..InpExtWorld4: input, 8 bits each. External input ports 1-4.
- OutExtWorld1..OutExtWorld4: output, 8 bits each. Registered output ports 1-4.
- Dataout1: output, 8 bits. Register-file read port A, R[Source1].
- Dataout2: output, 8 bits. Register-file read port B, R[Source2].
- ALUout: output, 8 bits. Combinational ALU result.
- OUTportWrite: output, 1 bit. High during T3 of an OUT instruction.

## Operation
- Core instance name is `uut`. It contains these state elements:
  - PC: 8 bits.
  - IR: 16 bits.
  - Timing generator `timing_gen`, a one-hot ring with phases T1, T2 and T3.
  - Register file `reg_file` with RegFileOut[0..15], 8 bits each. R0 is an ordinary register.
  - Halt flag.
- Decode fields: Opcode=IR[15:12], Destin=IR[11:8], Source1=IR[7:4], Source2=IR[3:0], imm=IR[7:0].
- RegFileWrite is asserted in T3 for: ADD, SUB, AND, OR, XOR, NOT, SHL, SHR, MOV, IN, LDI.
- Opcode actions (all arithmetic is 8-bit modulo 256; no carry or flags are stored):
  - 0000 NOP: no action.
  - 0001 ADD: Rd = Rs1 + Rs2.
  - 0010 SUB: Rd = Rs1 - Rs2.
  - 0011 AND: Rd = Rs1 & Rs2.
  - 0100 OR: Rd = Rs1 | Rs2.
  - 0101 XOR: Rd = Rs1 ^ Rs2.
  - 0110 NOT: Rd = ~Rs1.
  - 0111 SHL: Rd = Rs1 << 1, with 0 shifted in.
  - 1000 SHR: Rd = Rs1 >> 1, with 0 shifted in.
  - 1001 MOV: Rd = Rs1.
  - 1010 IN: Rd = InpExtWorld[Source1[1:0]+1].
  - 1011 OUT: OutExtWorld[Destin[1:0]+1] = Rs1. Asserts OUTportWrite.
  - 1100 LDI: Rd = imm.
  - 1101 JMP: PC = imm.
  - 1110 JZ: if R[Destin]==0 then PC = imm, else PC+1.
  - 1111 HLT: set halt.
- ALUout is combinational from Opcode, Dataout1 and Dataout2. For IN and LDI it carries the value being written. For opcodes with no defined result it is 00.
- Program ROM is 256 x 16, asynchronous read at PC. Addresses 0-10 hold the program below; every other address holds F000 (HLT).
  - 0: IN R1, port1.
  - 1: IN R2, port2.
  - 2: IN R3, port3.
  - 3: ADD R6, R1, R2.
  - 4: SUB R10, R2, R3.
  - 5: AND R13, R2, R1.
  - 6: OR R14, R1, R3.
  - 7: XOR R15, R2, R3.
  - 8: OUT port1, R6.
  - 9: OUT port2, R15.
  - 10: HLT.

## Timing
- Reset values, applied on a clock edge while Reset=1:
  - PC=00, IR=0000 (NOP), ring T1=1 and T2=T3=0, all registers 00, OutExtWorld1..4=00, halt=0.
  - Reset asserted mid-instruction aborts that instruction; no writeback occurs.
- Ring advances T1→T2→T3→T1 on each rising edge while not halted. One instruction takes exactly 3 cycles.
- Rising edge ending T1: IR <= ROM[PC].
- T2: combinational decode and register read. Dataout1, Dataout2 and ALUout are valid by the end of T2.
- Rising edge ending T3:
  - Register writeback, when RegFileWrite=1.
  - Output-port latch, for OUT.
  - PC <= PC+1 (8-bit wrap FF→00), or the branch target for JMP/JZ.
  - Halt set, for HLT.
- Read-during-write: in-flight instructions read the old register value. Writes are visible to the next instruction.
- Halted behaviour:
  - Ring freezes in T1. PC, IR, registers and ports are held.
  - OUTportWrite=0 and RegFileWrite=0.
  - Only Reset clears halt.
- OUTportWrite is combinational: high for exactly one cycle (T3) per OUT instruction.

## Test plan
- Reset held 1 cycle with inputs 04/0C/03/3C -> PC=00, T1=1, all RegFileOut=00, OutExtWorld1..4=00, OUTportWrite=0.
- Release reset and run 11 instructions (33 cycles) -> R1=04, R2=0C, R3=03, R6=10, R10=09, R13=04, R14=07, R15=0F.
- Same run -> OUTportWrite pulses once in T3 of PC=08 and once in T3 of PC=09. OutExtWorld1=10, OutExtWorld2=0F, OutExtWorld3=OutExtWorld4=00.
- During T3 of PC=03 -> Dataout1=04, Dataout2=0C, ALUout=10, RegFileWrite=1. During T3 of PC=04 -> ALUout=09.
- After HLT at PC=0A -> PC stays 0A and all registers unchanged for 100+ cycles. Asserting Reset for 1 cycle restarts the program from PC=00.
- Assert Reset during T2 of PC=03 -> R6 stays 00 and PC=00. The rerun then produces the same results as the second scenario.
